// File: rtl/fifo_ptr_ctrl_if.sv
// Handshake bundle between producer/consumer, the FIFO pointer controller and the storage RAM.
// The err_clr/overflow/underflow signals exist only when FIFO_CTRL_ERR_EN is defined.
interface fifo_ptr_ctrl_if #(
  parameter int ADDR_W = 4
);
  logic              wr_req;
  logic              rd_req;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   count;
`ifdef FIFO_CTRL_ERR_EN
  logic              err_clr;
  logic              overflow;
  logic              underflow;
`endif

  // Requester side: drives requests, observes strobes, addresses and flags.
  modport master (
    output wr_req, rd_req,
`ifdef FIFO_CTRL_ERR_EN
    output err_clr,
    input  overflow, underflow,
`endif
    input  wr_en, wr_addr, rd_en, rd_addr, rd_valid,
    input  full, empty, almost_full, almost_empty, count
  );

  // Controller side.
  modport slave (
    input  wr_req, rd_req,
`ifdef FIFO_CTRL_ERR_EN
    input  err_clr,
    output overflow, underflow,
`endif
    output wr_en, wr_addr, rd_en, rd_addr, rd_valid,
    output full, empty, almost_full, almost_empty, count
  );
endinterface

// File: rtl/fifo_ptr_ctrl.sv
// Write/read pointer and occupancy-flag controller for a synchronous 1R1W FIFO.
// Optional sticky overflow/underflow error flags are enabled by defining FIFO_CTRL_ERR_EN.
module fifo_ptr_ctrl #(
  parameter int ADDR_W   = 4,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2
) (
  input  logic            clock,
  input  logic            reset_n,
  fifo_ptr_ctrl_if.slave  bus
);
  localparam int PW = ADDR_W + 1;
  localparam logic [PW-1:0] ONE_C      = PW'(1);
  localparam logic [PW-1:0] ZERO_C     = PW'(0);
  localparam logic [PW-1:0] AF_LEVEL_C = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_LEVEL_C = PW'(AE_LEVEL);

  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] count_r;
  logic          full_r;
  logic          empty_r;
  logic          almost_full_r;
  logic          almost_empty_r;
  logic          rd_valid_r;

  logic          wa_s;
  logic          ra_s;
  logic [PW-1:0] wr_ptr_nxt_s;
  logic [PW-1:0] rd_ptr_nxt_s;
  logic [PW-1:0] count_nxt_s;
  logic          full_nxt_s;
  logic          empty_nxt_s;

  // Accepts are gated only by the registered flags, never by the opposite request.
  assign wa_s = bus.wr_req & ~full_r;
  assign ra_s = bus.rd_req & ~empty_r;

  // Next-state pointers and the occupancy/flags they imply.
  always_comb begin
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    if (wa_s) begin
      wr_ptr_nxt_s = wr_ptr_r + ONE_C;
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end
    if (ra_s) begin
      rd_ptr_nxt_s = rd_ptr_r + ONE_C;
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
    count_nxt_s = wr_ptr_nxt_s - rd_ptr_nxt_s;
    empty_nxt_s = (wr_ptr_nxt_s == rd_ptr_nxt_s);
    full_nxt_s  = (wr_ptr_nxt_s[ADDR_W] != rd_ptr_nxt_s[ADDR_W]) &&
                  (wr_ptr_nxt_s[ADDR_W-1:0] == rd_ptr_nxt_s[ADDR_W-1:0]);
  end

  // Pointer, occupancy, flag and read-valid registers; flags are registered copies of pointer-derived state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r       <= ZERO_C;
      rd_ptr_r       <= ZERO_C;
      count_r        <= ZERO_C;
      full_r         <= 1'b0;
      empty_r        <= 1'b1;
      almost_full_r  <= 1'b0;
      almost_empty_r <= 1'b1;
      rd_valid_r     <= 1'b0;
    end else begin
      wr_ptr_r       <= wr_ptr_nxt_s;
      rd_ptr_r       <= rd_ptr_nxt_s;
      count_r        <= count_nxt_s;
      full_r         <= full_nxt_s;
      empty_r        <= empty_nxt_s;
      almost_full_r  <= (count_nxt_s >= AF_LEVEL_C);
      almost_empty_r <= (count_nxt_s <= AE_LEVEL_C);
      rd_valid_r     <= ra_s;
    end
  end

  assign bus.wr_en        = wa_s;
  assign bus.rd_en        = ra_s;
  assign bus.wr_addr      = wr_ptr_r[ADDR_W-1:0];
  assign bus.rd_addr      = rd_ptr_r[ADDR_W-1:0];
  assign bus.rd_valid     = rd_valid_r;
  assign bus.count        = count_r;
  assign bus.full         = full_r;
  assign bus.empty        = empty_r;
  assign bus.almost_full  = almost_full_r;
  assign bus.almost_empty = almost_empty_r;

`ifdef FIFO_CTRL_ERR_EN
  logic overflow_r;
  logic underflow_r;

  // Sticky error flags; a clear request beats a same-cycle set.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else if (bus.err_clr) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (bus.wr_req && full_r) begin
        overflow_r <= 1'b1;
      end
      if (bus.rd_req && empty_r) begin
        underflow_r <= 1'b1;
      end
    end
  end

  assign bus.overflow  = overflow_r;
  assign bus.underflow = underflow_r;
`endif

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Directed self-checking bench for fifo_ptr_ctrl (ADDR_W=4, AF_LEVEL=14, AE_LEVEL=2).
module tb_fifo_ptr_ctrl;
  logic clock;
  logic reset_n;
  int   n_run;
  int   n_fail;

  fifo_ptr_ctrl_if #(.ADDR_W(4)) bus ();

  fifo_ptr_ctrl #(.ADDR_W(4), .AF_LEVEL(14), .AE_LEVEL(2)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;
`ifdef FIFO_CTRL_ERR_EN
    bus.err_clr = 1'b0;
`endif
    #12;
    n_run++; if (bus.count !== 5'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
    n_run++; if ({bus.empty, bus.almost_empty, bus.full, bus.almost_full} !== 4'b1100) begin n_fail++; $display("FAIL reset_flags got=%b exp=1100", {bus.empty, bus.almost_empty, bus.full, bus.almost_full}); end
    n_run++; if ({bus.wr_en, bus.rd_en, bus.rd_valid} !== 3'b000) begin n_fail++; $display("FAIL reset_strobes got=%b exp=000", {bus.wr_en, bus.rd_en, bus.rd_valid}); end
`ifdef FIFO_CTRL_ERR_EN
    n_run++; if ({bus.overflow, bus.underflow} !== 2'b00) begin n_fail++; $display("FAIL reset_err got=%b exp=00", {bus.overflow, bus.underflow}); end
`endif
    #2 reset_n = 1'b1;
    tick();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      bus.wr_req = 1'b1;
      #1;
      n_run++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 4'(i)) begin n_fail++; $display("FAIL fill_wr i=%0d got en=%b addr=%0d exp en=1 addr=%0d", i, bus.wr_en, bus.wr_addr, i); end
      tick();
      n_run++; if (bus.count !== 5'(i + 1)) begin n_fail++; $display("FAIL fill_count i=%0d got=%0d exp=%0d", i, bus.count, i + 1); end
      n_run++; if ({bus.full, bus.almost_full, bus.empty, bus.almost_empty} !== {(i + 1 == 16), (i + 1 >= 14), 1'b0, (i + 1 <= 2)}) begin
        n_fail++; $display("FAIL fill_flags i=%0d got f/af/e/ae=%b exp=%b", i, {bus.full, bus.almost_full, bus.empty, bus.almost_empty}, {(i + 1 == 16), (i + 1 >= 14), 1'b0, (i + 1 <= 2)});
      end
    end
    #1;
    n_run++; if (bus.wr_en !== 1'b0) begin n_fail++; $display("FAIL full_blocks_wr got=%b exp=0", bus.wr_en); end
    bus.wr_req = 1'b0;
  endtask

  task automatic test_full_both();
    bus.wr_req = 1'b1;
    bus.rd_req = 1'b1;
    #1;
    n_run++; if ({bus.wr_en, bus.rd_en} !== 2'b01 || bus.rd_addr !== 4'd0) begin n_fail++; $display("FAIL full_both got wr=%b rd=%b rd_addr=%0d exp wr=0 rd=1 rd_addr=0", bus.wr_en, bus.rd_en, bus.rd_addr); end
    tick();
    n_run++; if (bus.count !== 5'd15 || bus.full !== 1'b0) begin n_fail++; $display("FAIL full_both_next got count=%0d full=%b exp 15/0", bus.count, bus.full); end
    n_run++; if (bus.rd_valid !== 1'b1) begin n_fail++; $display("FAIL full_both_rvalid got=%b exp=1", bus.rd_valid); end
    bus.wr_req = 1'b0;
  endtask

  task automatic test_drain();
    for (int i = 1; i < 16; i++) begin
      bus.rd_req = 1'b1;
      #1;
      n_run++; if (bus.rd_en !== 1'b1 || bus.rd_addr !== 4'(i)) begin n_fail++; $display("FAIL drain_rd i=%0d got en=%b addr=%0d exp en=1 addr=%0d", i, bus.rd_en, bus.rd_addr, i); end
      tick();
      n_run++; if (bus.count !== 5'(15 - i) || bus.almost_empty !== (15 - i <= 2)) begin n_fail++; $display("FAIL drain_count i=%0d got=%0d ae=%b exp=%0d", i, bus.count, bus.almost_empty, 15 - i); end
    end
    n_run++; if (bus.empty !== 1'b1 || bus.rd_valid !== 1'b1) begin n_fail++; $display("FAIL drain_end got empty=%b rvalid=%b exp 1/1", bus.empty, bus.rd_valid); end
    #1;
    n_run++; if (bus.rd_en !== 1'b0) begin n_fail++; $display("FAIL empty_blocks_rd got=%b exp=0", bus.rd_en); end
    bus.rd_req = 1'b0;
    tick();
    n_run++; if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL drain_rvalid_drop got=%b exp=0", bus.rd_valid); end
  endtask

  task automatic test_empty_both();
    bus.wr_req = 1'b1;
    bus.rd_req = 1'b1;
    #1;
    n_run++; if ({bus.wr_en, bus.rd_en} !== 2'b10 || bus.wr_addr !== 4'd0) begin n_fail++; $display("FAIL empty_both got wr=%b rd=%b wr_addr=%0d exp wr=1 rd=0 wr_addr=0", bus.wr_en, bus.rd_en, bus.wr_addr); end
    tick();
    n_run++; if (bus.count !== 5'd1 || bus.empty !== 1'b0 || bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL empty_both_next got count=%0d empty=%b rvalid=%b exp 1/0/0", bus.count, bus.empty, bus.rd_valid); end
  endtask

  task automatic test_back_to_back();
    // wr_ptr=17, rd_ptr=16 on entry; 40 pairs wrap both pointers past 31.
    for (int i = 0; i < 40; i++) begin
      bus.wr_req = 1'b1;
      bus.rd_req = 1'b1;
      #1;
      n_run++; if ({bus.wr_en, bus.rd_en} !== 2'b11 || bus.wr_addr !== 4'((17 + i) % 16) || bus.rd_addr !== 4'((16 + i) % 16)) begin
        n_fail++; $display("FAIL b2b_addr i=%0d got en=%b%b wa=%0d ra=%0d exp en=11 wa=%0d ra=%0d", i, bus.wr_en, bus.rd_en, bus.wr_addr, bus.rd_addr, (17 + i) % 16, (16 + i) % 16);
      end
      n_run++; if (bus.rd_valid !== (i != 0)) begin n_fail++; $display("FAIL b2b_rvalid_pre i=%0d got=%b exp=%b", i, bus.rd_valid, (i != 0)); end
      tick();
      n_run++; if (bus.count !== 5'd1 || bus.rd_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_count i=%0d got count=%0d rvalid=%b exp 1/1", i, bus.count, bus.rd_valid); end
    end
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;
    tick();
    n_run++; if (bus.rd_valid !== 1'b0 || bus.wr_addr !== 4'd9 || bus.rd_addr !== 4'd8) begin n_fail++; $display("FAIL b2b_end got rvalid=%b wa=%0d ra=%0d exp 0/9/8", bus.rd_valid, bus.wr_addr, bus.rd_addr); end
  endtask

  task automatic test_async_reset();
    bus.wr_req = 1'b1;
    bus.rd_req = 1'b1;
    tick();
    bus.wr_req = 1'b1;
    bus.rd_req = 1'b0;
    tick();
    n_run++; if (bus.count !== 5'd2 || bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL pre_reset got count=%0d rvalid=%b exp 2/0", bus.count, bus.rd_valid); end
    bus.rd_req = 1'b1;
    tick();
    #3;
    reset_n = 1'b0;
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;
    #1;
    n_run++; if (bus.count !== 5'd0 || bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL async_reset_count got count=%0d rvalid=%b exp 0/0", bus.count, bus.rd_valid); end
    n_run++; if ({bus.empty, bus.almost_empty, bus.full, bus.almost_full, bus.wr_en, bus.rd_en} !== 6'b110000) begin n_fail++; $display("FAIL async_reset_flags got=%b exp=110000", {bus.empty, bus.almost_empty, bus.full, bus.almost_full, bus.wr_en, bus.rd_en}); end
    n_run++; if (bus.wr_addr !== 4'd0 || bus.rd_addr !== 4'd0) begin n_fail++; $display("FAIL async_reset_addr got wa=%0d ra=%0d exp 0/0", bus.wr_addr, bus.rd_addr); end
    #2 reset_n = 1'b1;
    tick();
    bus.wr_req = 1'b1;
    #1;
    n_run++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 4'd0) begin n_fail++; $display("FAIL post_reset_wr got en=%b addr=%0d exp 1/0", bus.wr_en, bus.wr_addr); end
    tick();
    bus.wr_req = 1'b0;
    n_run++; if (bus.count !== 5'd1) begin n_fail++; $display("FAIL post_reset_count got=%0d exp=1", bus.count); end
  endtask

`ifdef FIFO_CTRL_ERR_EN
  task automatic test_errors();
    // Entry: count=1. Drain to empty, then provoke underflow.
    bus.rd_req = 1'b1;
    tick();
    n_run++; if (bus.underflow !== 1'b0) begin n_fail++; $display("FAIL uf_no_set got=%b exp=0", bus.underflow); end
    tick();
    n_run++; if (bus.underflow !== 1'b1) begin n_fail++; $display("FAIL uf_set got=%b exp=1", bus.underflow); end
    bus.rd_req = 1'b0;
    tick();
    n_run++; if (bus.underflow !== 1'b1) begin n_fail++; $display("FAIL uf_hold got=%b exp=1", bus.underflow); end
    bus.err_clr = 1'b1;
    bus.rd_req = 1'b1;
    tick();
    n_run++; if (bus.underflow !== 1'b0) begin n_fail++; $display("FAIL uf_clr_wins got=%b exp=0", bus.underflow); end
    bus.err_clr = 1'b0;
    bus.rd_req = 1'b0;
    bus.wr_req = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    n_run++; if (bus.full !== 1'b1 || bus.overflow !== 1'b0) begin n_fail++; $display("FAIL of_pre got full=%b of=%b exp 1/0", bus.full, bus.overflow); end
    tick();
    bus.wr_req = 1'b0;
    n_run++; if (bus.overflow !== 1'b1 || bus.count !== 5'd16) begin n_fail++; $display("FAIL of_set got of=%b count=%0d exp 1/16", bus.overflow, bus.count); end
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    n_run++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL of_clr got=%b exp=0", bus.overflow); end
  endtask
`endif

  initial begin
    n_run  = 0;
    n_fail = 0;
    test_reset();
    test_fill();
    test_full_both();
    test_drain();
    test_empty_both();
    test_back_to_back();
    test_async_reset();
`ifdef FIFO_CTRL_ERR_EN
    test_errors();
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
